dma_copy_ctrl: RTL and testbench

Word-copy DMA engine that sits directly upstream of the memory controller and acts as its only request master. A host programs source address, destination address and word count, pulses start, and the block moves the block of words with alternating single-word read and write transactions over the controller's request/acknowledge port. It signals completion with a done pulse and reports controller errors.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_copy_ctrl_if.sv | 25 ++
 rtl/dma_copy_ctrl.sv | 144 ++++++++++++++
 tb/tb_dma_copy_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the word-copy DMA engine and its memory controller port.
package dma_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  localparam logic MC_WE_READ  = 1'b0;
  localparam logic MC_WE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_copy_ctrl_if.sv
// Request/acknowledge port between the DMA engine (master) and the memory controller (slave).
interface dma_copy_ctrl_if #(
  parameter int DATA_W = dma_pkg::DATA_W_DEF,
  parameter int ADDR_W = dma_pkg::ADDR_W_DEF
) ();

  logic              mc_req;
  logic              mc_we;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_ack;
  logic [DATA_W-1:0] mc_rdata;
  logic              mc_err;

  modport master (
    output mc_req, mc_we, mc_addr, mc_wdata,
    input  mc_ack, mc_rdata, mc_err
  );

  modport slave (
    input  mc_req, mc_we, mc_addr, mc_wdata,
    output mc_ack, mc_rdata, mc_err
  );

endinterface

// File: rtl/dma_copy_ctrl.sv
// Word-copy DMA: alternating single-word read/write transactions, ascending addresses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for dma_start; latches src/dst/length on start
// ST_READ   | read request at src_ptr outstanding until mc_ack
// ST_WRITE  | write request of buffered word at dst_ptr until mc_ack
// ST_FINISH | one-cycle dma_done pulse, then back to idle
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              dma_clk,
  input  logic              dma_reset,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src_addr,
  input  logic [ADDR_W-1:0] dma_dst_addr,
  input  logic [LEN_W-1:0]  dma_length,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_err,
  dma_copy_ctrl_if.master   mc
);

  dma_state_e        state_q;
  logic [ADDR_W-1:0] src_ptr_q, dst_ptr_q;
  logic [ADDR_W-1:0] src_ptr_d, dst_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              busy_q, done_q, err_q;
  logic              mc_req_q, mc_we_q;
  logic [ADDR_W-1:0] mc_addr_q;
  logic [DATA_W-1:0] mc_wdata_q;
  logic              last_word;

  // Pointers wrap modulo 2^ADDR_W by plain truncation.
  assign src_ptr_d = src_ptr_q + ADDR_W'(1);
  assign dst_ptr_d = dst_ptr_q + ADDR_W'(1);
  assign remain_d  = remain_q - LEN_W'(1);
  assign last_word = (remain_q == LEN_W'(1));

  always_ff @(posedge dma_clk or negedge dma_reset) begin
    if (!dma_reset) begin
      state_q    <= ST_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      remain_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mc_req_q   <= 1'b0;
      mc_we_q    <= MC_WE_READ;
      mc_addr_q  <= '0;
      mc_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (dma_start) begin
            src_ptr_q <= dma_src_addr;
            dst_ptr_q <= dma_dst_addr;
            remain_q  <= dma_length;
            err_q     <= 1'b0;
            if (dma_length == '0) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_READ;
              busy_q    <= 1'b1;
              mc_req_q  <= 1'b1;
              mc_we_q   <= MC_WE_READ;
              mc_addr_q <= dma_src_addr;
            end
          end
        end

        ST_READ: begin
          if (mc.mc_ack) begin
            if (mc.mc_err) begin
              state_q  <= ST_FINISH;
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              mc_req_q <= 1'b0;
            end else begin
              state_q    <= ST_WRITE;
              mc_we_q    <= MC_WE_WRITE;
              mc_addr_q  <= dst_ptr_q;
              mc_wdata_q <= mc.mc_rdata;
            end
          end
        end

        ST_WRITE: begin
          if (mc.mc_ack) begin
            if (mc.mc_err) begin
              state_q  <= ST_FINISH;
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              mc_req_q <= 1'b0;
            end else begin
              src_ptr_q <= src_ptr_d;
              dst_ptr_q <= dst_ptr_d;
              remain_q  <= remain_d;
              if (last_word) begin
                state_q  <= ST_FINISH;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                mc_req_q <= 1'b0;
              end else begin
                // Next read goes out back-to-back; request stays high.
                state_q   <= ST_READ;
                mc_we_q   <= MC_WE_READ;
                mc_addr_q <= src_ptr_d;
              end
            end
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          mc_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dma_busy    = busy_q;
  assign dma_done    = done_q;
  assign dma_err     = err_q;
  assign mc.mc_req   = mc_req_q;
  assign mc.mc_we    = mc_we_q;
  assign mc.mc_addr  = mc_addr_q;
  assign mc.mc_wdata = mc_wdata_q;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Bench for dma_copy_ctrl: randomized memory-controller responder checked against a
// transaction-list model of the copy.
module tb_dma_copy_ctrl;
  import dma_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;

  dma_copy_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mc_bus ();

  dma_copy_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) u_dut (
    .dma_clk      (clk),
    .dma_reset    (rst_n),
    .dma_start    (start),
    .dma_src_addr (src),
    .dma_dst_addr (dst),
    .dma_length   (len),
    .dma_busy     (busy),
    .dma_done     (done),
    .dma_err      (err),
    .mc           (mc_bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] salt;
  txn_t        exp_q[$];
  txn_t        obs_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Memory contents seen by the engine: a salted function of the word address.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, ~a} ^ salt;
  endfunction

  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] l, input int minw, input int maxw,
                          input int err_at, input int restart_at, input bit abort_wr,
                          input string nm);
    int            wl, txn, waits, done_cyc, budget, cyc;
    bit            in_txn, stable, fin;
    txn_t          cur, now;
    logic [AW-1:0] ra, wa;

    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < int'(l); i++) begin
      ra = s + AW'(i);
      wa = d + AW'(i);
      exp_q.push_back('{1'b0, ra, '0});
      exp_q.push_back('{1'b1, wa, pat(ra)});
    end
    if (err_at >= 0)
      while (exp_q.size() > err_at + 1) void'(exp_q.pop_back());

    wl = 0; txn = 0; waits = 0; done_cyc = -1;
    in_txn = 0; stable = 1; fin = 0; cur = '0;
    budget = 2 * int'(l) * (maxw + 1) + 20;

    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src = AW'($urandom); dst = AW'($urandom); len = LW'($urandom);
    chk({nm, "_busy_c1"}, busy, (l != 0));
    chk({nm, "_err_c1"}, err, 0);

    for (cyc = 1; cyc <= budget && !fin; cyc++) begin
      start = (cyc == restart_at);
      if (start) begin src = ~s; dst = ~d; len = l + LW'(5); end
      mc_bus.mc_ack = 1'b0;
      mc_bus.mc_err = 1'b0;
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_req_at_done"}, mc_bus.mc_req, 0);
      end else if (mc_bus.mc_req) begin
        now = '{mc_bus.mc_we, mc_bus.mc_addr, mc_bus.mc_we ? mc_bus.mc_wdata : '0};
        if (!in_txn) begin
          in_txn = 1;
          stable = 1;
          cur = now;
          wl = abort_wr ? 2 : int'($urandom_range(maxw, minw));
          waits += wl;
        end else if (now != cur) begin
          stable = 0;
        end
        if (abort_wr && cur.we && wl > 0) begin
          #2 rst_n = 1'b0;
          #1;
          chk({nm, "_rst_req"}, mc_bus.mc_req, 0);
          chk({nm, "_rst_busy"}, busy, 0);
          repeat (3) begin
            @(negedge clk);
            chk({nm, "_rst_quiet"}, {done, mc_bus.mc_req, busy}, 0);
          end
          start = 1'b0;
          rst_n = 1'b1;
          return;
        end
        if (wl == 0) begin
          mc_bus.mc_ack = 1'b1;
          mc_bus.mc_err = (txn == err_at);
          mc_bus.mc_rdata = cur.we ? DW'($urandom) : pat(cur.addr);
          chk({nm, "_stable"}, stable, 1);
          obs_q.push_back(cur);
          in_txn = 0;
          txn++;
        end else begin
          wl--;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        mc_bus.mc_ack = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mc_bus.mc_ack = 1'b0;
    mc_bus.mc_err = 1'b0;

    chk({nm, "_finished"}, fin, 1);
    chk({nm, "_done_cyc"}, done_cyc, exp_q.size() + waits + 1);
    chk({nm, "_txn_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({nm, "_txn"}, 64'(obs_q[i]), 64'(exp_q[i]));
    chk({nm, "_err"}, err, (err_at >= 0 && err_at < 2 * int'(l)));
    repeat (3) begin
      chk({nm, "_after"}, {done, mc_bus.mc_req, busy}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int            l, e;
    mc_bus.mc_ack = 1'b0;
    mc_bus.mc_err = 1'b0;
    mc_bus.mc_rdata = '0;
    salt = $urandom;
    #1;
    chk("rst_out", {busy, done, err, mc_bus.mc_req, mc_bus.mc_we}, 0);
    chk("rst_addr", mc_bus.mc_addr, 0);
    chk("rst_wdata", mc_bus.mc_wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_xfer(16'h0010, 16'h0100, 4, 0, 0, -1, 0, 0, "basic");
    run_xfer(16'h0200, 16'h0300, 3, 3, 3, -1, 4, 0, "wait3");
    run_xfer(16'h1234, 16'h4321, 0, 0, 0, -1, 1, 0, "len0");
    run_xfer(16'h0400, 16'h0500, 5, 0, 1, 2, 0, 0, "rderr");
    run_xfer(16'h0600, 16'h0700, 2, 0, 1, -1, 0, 0, "errclr");
    run_xfer(16'hFFFF, 16'hFFFE, 3, 0, 2, -1, 0, 0, "wrap");
    run_xfer(16'h0800, 16'h0900, 3, 2, 2, -1, 0, 1, "abort");
    run_xfer(16'h0A00, 16'h0B00, 3, 0, 1, -1, 3, 0, "postrst");
    for (int r = 0; r < 8; r++) begin
      l = int'($urandom_range(6, 0));
      e = (l > 0 && $urandom_range(2, 0) == 0) ? int'($urandom_range(2 * l - 1, 0)) : -1;
      run_xfer(AW'($urandom), AW'($urandom), LW'(l), 0, 2, e,
               int'($urandom_range(4, 0)), 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
